// File: rtl/burst_unloader.sv
// ----------------------------------------------------------------------------
// burst_unloader
//
// Captures a fixed-length burst of CYCLES words following a data_start strobe,
// then drains the burst to a downstream consumer over a valid/ready handshake.
// Start strobes that arrive while a burst is being captured or drained are
// dropped and reported with a one-cycle overrun pulse. The only exception is
// a strobe on the final drain transfer, which chains straight into the next
// capture with no idle bubble.
//
// Parameters
//   WIDTH       data word width in bits
//   CYCLES      words per burst (>= 2)
//
// Ports
//   clock       in   1       rising-edge clock for all state
//   reset       in   1       synchronous, active-high reset
//   data_start  in   1       burst start strobe
//   data        in   WIDTH   input word, stored on every CAPTURE edge
//   out_valid   out  1       out_data/out_index/out_last are valid (DRAIN)
//   out_ready   in   1       consumer accepts the presented word this cycle
//   out_data    out  WIDTH   current burst word
//   out_index   out  IW      position of out_data within the burst
//   out_last    out  1       high with out_valid on the final word
//   busy        out  1       unit is capturing or draining
//   frame_done  out  1       one-cycle pulse after the last word transfers
//   overrun     out  1       one-cycle pulse when a start strobe is dropped
// ----------------------------------------------------------------------------
module burst_unloader #(
  parameter  int WIDTH  = 16,
  parameter  int CYCLES = 8,
  localparam int IW     = $clog2(CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_start,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [IW-1:0] LAST_PTR = IW'(CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_wr_ptr;
  logic [IW-1:0]    r_rd_ptr;
  logic             r_frame_done;
  logic             r_overrun;
  logic [WIDTH-1:0] r_mem [CYCLES];

  logic w_in_capture;
  logic w_in_drain;
  logic w_xfer;
  logic w_final_xfer;

  assign w_in_capture = (r_state == S_CAPTURE);
  assign w_in_drain   = (r_state == S_DRAIN);
  assign w_xfer       = w_in_drain & out_ready;
  assign w_final_xfer = w_xfer & (r_rd_ptr == LAST_PTR);

  // --------------------------------------------------------------------------
  // Burst storage. Deliberately not reset: contents are only ever observed in
  // DRAIN, after a full burst has been written.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_in_capture) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered status pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // The word present on the strobe edge is not part of the burst.
          if (data_start) begin
            r_state  <= S_CAPTURE;
            r_wr_ptr <= '0;
          end
        end

        S_CAPTURE: begin
          // Capture has no valid qualifier: every edge stores a word.
          if (r_wr_ptr == LAST_PTR) begin
            r_state  <= S_DRAIN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (data_start) begin
            r_overrun <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (w_final_xfer) begin
            r_frame_done <= 1'b1;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            // A strobe on the final transfer starts the next burst directly.
            r_state      <= data_start ? S_CAPTURE : S_IDLE;
          end else begin
            if (w_xfer) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (data_start) begin
              r_overrun <= 1'b1;
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Everything here depends only on registered state and
  // pointers, so out_valid has no combinational path from out_ready and all
  // outputs hold while the consumer stalls.
  // --------------------------------------------------------------------------
  assign out_valid  = w_in_drain;
  assign out_data   = w_in_drain ? r_mem[r_rd_ptr] : '0;
  assign out_index  = w_in_drain ? r_rd_ptr : '0;
  assign out_last   = w_in_drain & (r_rd_ptr == LAST_PTR);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_burst_unloader.sv
// ----------------------------------------------------------------------------
// tb_burst_unloader
//
// Scoreboard bench for burst_unloader. Stimulus tasks push the expected
// {data, index, last} of every word they feed in; an independent monitor pops
// and compares on every out_valid & out_ready, checks that stalled outputs
// hold, and counts frame_done / overrun pulses for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_burst_unloader;

  localparam int WIDTH  = 16;
  localparam int CYCLES = 8;
  localparam int IW     = 3;

  logic             clock      = 1'b0;
  logic             reset      = 1'b1;
  logic             data_start = 1'b0;
  logic [WIDTH-1:0] data       = '0;
  logic             out_ready  = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_index;
  logic             out_last;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  always #5 clock = ~clock;

  burst_unloader #(.WIDTH(WIDTH), .CYCLES(CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_start (data_start),
    .data       (data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [IW-1:0]    idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int passed   = 0;
  int fd_cnt   = 0;
  int ov_cnt   = 0;
  int rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0 repeating, 2: never
  int rdy_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Consumer ready driver, a little after the stimulus so mode changes land
  // in the same cycle.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1: begin
          out_ready = ((rdy_phase % 3) == 0);
          rdy_phase++;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on transfer, hold check on stall, pulse counters.
  initial begin
    logic             stalled;
    logic [WIDTH-1:0] hold_d;
    logic [IW-1:0]    hold_i;
    logic             hold_l;
    exp_t             e;
    stalled = 1'b0;
    hold_d  = '0;
    hold_i  = '0;
    hold_l  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data",  32'(out_data),  32'(hold_d));
          check("hold_index", 32'(out_index), 32'(hold_i));
          check("hold_last",  32'(out_last),  32'(hold_l));
        end
        stalled = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got data %0h index %0d, expected no transfer",
                     out_data, out_index);
          end else begin
            e = exp_q.pop_front();
            check("word_data",  32'(out_data),  32'(e.d));
            check("word_index", 32'(out_index), 32'(e.idx));
            check("word_last",  32'(out_last),  32'(e.last));
          end
        end else if (out_valid) begin
          stalled = 1'b1;
          hold_d  = out_data;
          hold_i  = out_index;
          hold_l  = out_last;
        end
        if (frame_done) fd_cnt++;
        if (overrun)    ov_cnt++;
      end
    end
  end

  // Strobe, then feed CYCLES words; optionally raise data_start alongside
  // word ovr_at to provoke a capture-time overrun.
  task automatic send_burst(input logic [WIDTH-1:0] base, input int ovr_at);
    exp_t e;
    data_start = 1'b1;
    step();
    for (int i = 0; i < CYCLES; i++) begin
      data       = base + WIDTH'(i);
      data_start = (i == ovr_at);
      e.d    = base + WIDTH'(i);
      e.idx  = IW'(i);
      e.last = (i == CYCLES - 1);
      exp_q.push_back(e);
      if (i == CYCLES - 1) check("valid_before_latency", 32'(out_valid), 32'd0);
      step();
    end
    data_start = 1'b0;
    data       = '0;
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_index", 32'(out_index), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, 32'(out_valid),  32'd0);
    check({name, "_data"},  32'(out_data),   32'd0);
    check({name, "_index"}, 32'(out_index),  32'd0);
    check({name, "_last"},  32'(out_last),   32'd0);
    check({name, "_busy"},  32'(busy),       32'd0);
    check({name, "_fdone"}, 32'(frame_done), 32'd0);
    check({name, "_ovr"},   32'(overrun),    32'd0);
  endtask

  initial begin
    int   fd0;
    int   ov0;
    logic found;

    // 1: reset
    reset = 1'b1;
    repeat (3) step();
    check_quiet("reset");
    reset = 1'b0;
    step();

    // 2: single burst, consumer always ready
    rdy_mode = 0;
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    send_burst(16'h0100, -1);
    wait_idle("t2_drain_done", 100);
    check("t2_fd_pulse", 32'(frame_done), 32'd1);
    step();
    check("t2_fd_single", 32'(frame_done), 32'd0);
    check("t2_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("t2_ov_count", 32'(ov_cnt - ov0), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);

    // 3: stalling consumer
    rdy_mode  = 1;
    rdy_phase = 0;
    fd0 = fd_cnt;
    send_burst(16'h0300, -1);
    wait_idle("t3_drain_done", 200);
    step();
    check("t3_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("t3_busy_after", 32'(busy), 32'd0);

    // 4: dropped strobes mid-capture and mid-drain
    rdy_mode = 0;
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    send_burst(16'h0400, 3);
    step();
    step();
    data_start = 1'b1;
    step();
    data_start = 1'b0;
    wait_idle("t4_drain_done", 100);
    repeat (3) step();
    check("t4_ov_count", 32'(ov_cnt - ov0), 32'd2);
    check("t4_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("t4_stays_idle", 32'(busy), 32'd0);

    // 5: back-to-back bursts A then B, strobe on A's final transfer
    rdy_mode = 0;
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    send_burst(16'h00A0, -1);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid && out_last) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t5_reach_last", 32'(found), 32'd1);
    send_burst(16'h00B0, -1);
    wait_idle("t5_drain_done", 100);
    step();
    check("t5_ov_count", 32'(ov_cnt - ov0), 32'd0);
    check("t5_fd_count", 32'(fd_cnt - fd0), 32'd2);

    // 6: reset in the middle of a drain
    rdy_mode = 0;
    send_burst(16'h0600, -1);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid && out_index == 3'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t6_reach_idx3", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    check_quiet("t6_after_reset");
    exp_q.delete();
    fd0 = fd_cnt;
    reset = 1'b0;
    repeat (3) step();
    check("t6_no_fd", 32'(fd_cnt - fd0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    send_burst(16'h0700, -1);
    wait_idle("t6_drain_done", 100);
    step();
    check("t6_fd_count", 32'(fd_cnt - fd0), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
